// File: rtl/spi_cmd_seq_if.sv
// spi_cmd_seq_if
//   Bundles every non-clock, non-reset signal of the SPI command sequencer:
//   the host request channel, the command channel to the SPI master, the
//   read-data return from the SPI master, the read-response channel back to
//   the host, and the busy status flag.
//
//   Modports:
//     slave  - the sequencer side (spi_cmd_seq)
//     master - the environment side (host + SPI master, or a testbench)
//
//   Signals:
//     req_vld/req_rdy/req_wr/req_addr/req_wdata  host request handshake
//     cmd_out/cmd_vld/cmd_rdy                    command word to SPI master
//     read_vld/read_data                         SPI master read return
//     rsp_vld/rsp_rdy/rsp_data/rsp_addr/
//     rsp_timeout                                read response to host
//     busy                                       FIFO non-empty or FSM active
interface spi_cmd_seq_if #(
  parameter int CMD_WIDTH  = 12,
  parameter int READ_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);

  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [READ_WIDTH-1:0] req_wdata;

  logic [CMD_WIDTH-1:0]  cmd_out;
  logic                  cmd_vld;
  logic                  cmd_rdy;

  logic                  read_vld;
  logic [READ_WIDTH-1:0] read_data;

  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [READ_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_timeout;

  logic                  busy;

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata,
    input  cmd_rdy,
    input  read_vld, read_data,
    input  rsp_rdy,
    output req_rdy,
    output cmd_out, cmd_vld,
    output rsp_vld, rsp_data, rsp_addr, rsp_timeout,
    output busy
  );

  modport master (
    output req_vld, req_wr, req_addr, req_wdata,
    output cmd_rdy,
    output read_vld, read_data,
    output rsp_rdy,
    input  req_rdy,
    input  cmd_out, cmd_vld,
    input  rsp_vld, rsp_data, rsp_addr, rsp_timeout,
    input  busy
  );

endinterface

// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq
//   Command sequencer in front of the SPI master. Host requests are formatted
//   into {wr, addr, wr ? wdata : 0} at push time and queued in a small FIFO.
//   A four-state FSM (IDLE, ISSUE, WAIT_RD, RSP) issues one command at a time
//   on cmd_vld/cmd_rdy; reads wait for read_vld and return the data to the
//   host on rsp_vld/rsp_rdy. Only one read is ever outstanding.
//
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    spi_cmd_seq_if.slave (request, command, read return, response,
//            busy)
//
//   Optional feature macro: SPI_SEQ_TIMEOUT_EN
//     Defined   - a WAIT_RD cycle counter forces an all-ones response with
//                 rsp_timeout = 1 after TIMEOUT_CYCLES cycles without read_vld.
//     Undefined - WAIT_RD waits indefinitely and rsp_timeout is always 0.
module spi_cmd_seq #(
  parameter int CMD_WIDTH      = 12,
  parameter int READ_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_cmd_seq_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Reject configurations the packing and pointer-wrap logic cannot handle.
  if ((CMD_WIDTH != 1 + ADDR_WIDTH + READ_WIDTH) || (FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 2)) begin : g_bad_params
    $error("spi_cmd_seq: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RSP} state_t;

  state_t                state_q, state_d;

  logic [CMD_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  logic                  full, empty, push, pop;
  logic [CMD_WIDTH-1:0]  push_word, head;

  logic [CMD_WIDTH-1:0]  cmd_out_q, cmd_out_d;
  logic                  cmd_vld_q, cmd_vld_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic [READ_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  to_hit;

  assign full      = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = bus.req_vld && !full;
  assign head      = mem[rd_ptr];
  // Write data is zeroed for reads so the stored word is fully defined.
  assign push_word = {bus.req_wr, bus.req_addr,
                      bus.req_wr ? bus.req_wdata : {READ_WIDTH{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q;

  // Holds at zero outside WAIT_RD, so the first WAIT_RD cycle sees 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q != WAIT_RD) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmd_out_q     <= '0;
      cmd_vld_q     <= 1'b0;
      rsp_vld_q     <= 1'b0;
      rsp_data_q    <= '0;
      rsp_addr_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_out_q     <= cmd_out_d;
      cmd_vld_q     <= cmd_vld_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_data_q    <= rsp_data_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // read_vld is only looked at in WAIT_RD; in every other state it is dropped.
  always_comb begin
    state_d       = state_q;
    cmd_out_d     = cmd_out_q;
    cmd_vld_d     = cmd_vld_q;
    rsp_vld_d     = rsp_vld_q;
    rsp_data_d    = rsp_data_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_timeout_d = rsp_timeout_q;
    pop           = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d   = ISSUE;
          cmd_out_d = head;
          cmd_vld_d = 1'b1;
        end
      end
      ISSUE: begin
        if (cmd_vld_q && bus.cmd_rdy) begin
          pop       = 1'b1;
          cmd_vld_d = 1'b0;
          if (cmd_out_q[CMD_WIDTH-1]) begin
            state_d = IDLE;
          end else begin
            rsp_addr_d = cmd_out_q[READ_WIDTH +: ADDR_WIDTH];
            state_d    = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        // A real read_vld on the terminal count still beats the timeout.
        if (bus.read_vld) begin
          rsp_data_d    = bus.read_data;
          rsp_vld_d     = 1'b1;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end else if (to_hit) begin
          rsp_data_d    = '1;
          rsp_vld_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_rdy) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_rdy     = !full;
  assign bus.cmd_out     = cmd_out_q;
  assign bus.cmd_vld     = cmd_vld_q;
  assign bus.rsp_vld     = rsp_vld_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_addr    = rsp_addr_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.busy        = (state_q != IDLE) || !empty;

endmodule
